// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bundle: IF push side, ID head side, stall/flush and occupancy.
// The master modport is the IF/ID control side; the slave modport is the queue itself.
interface if_id_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
    logic              flush;
    logic              EN;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   PCplus4In;
    logic [DATA_W-1:0] instructionIn;
    logic              out_valid;
    logic [PC_W-1:0]   PCplus4Out;
    logic [DATA_W-1:0] instructionOut;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, EN, in_valid, PCplus4In, instructionIn,
        input  in_ready, out_valid, PCplus4Out, instructionOut, count
    );

    modport slave (
        input  flush, EN, in_valid, PCplus4In, instructionIn,
        output in_ready, out_valid, PCplus4Out, instructionOut, count
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction FIFO. Fetch may run ahead of a stalled decode stage.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module if_id_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 4
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave q
);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + DATA_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    logic full, empty, push, pop;
    logic [ENTRY_W-1:0] head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = q.in_valid && !full;
    assign pop   = q.EN && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (q.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {q.PCplus4In, q.instructionIn};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; an empty queue masks its outputs to zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head             = mem_q[rd_ptr_q];
    assign q.in_ready       = !full;
    assign q.out_valid      = !empty;
    assign q.count          = count_q;
    assign q.PCplus4Out     = empty ? '0 : head[ENTRY_W-1:DATA_W];
    assign q.instructionOut = empty ? '0 : head[DATA_W-1:0];

    count_in_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised fetch-to-decode instruction queue. Replaces the single-entry IF/ID pipeline register with a DEPTH-entry FIFO, so fetch can run ahead of a stalled decode stage. It sits between the IF stage (PC+4 and instruction producer) and the ID stage (consumer). It keeps the familiar stall (EN) and flush controls, and adds valid/ready handshaking and occupancy reporting.

Parameters:
DATA_W, 32, instruction width in bits
PC_W, 32, PC+4 width in bits
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  discard all queued entries (branch/jump redirect)
EN  input  1  decode advance; 1 = ID consumes the head entry this cycle, 0 = ID stalled
in_valid  input  1  IF presents an entry this cycle
in_ready  output  1  queue can accept an entry this cycle
PCplus4In  input  PC_W  PC+4 of the incoming instruction
instructionIn  input  DATA_W  incoming instruction word
out_valid  output  1  head entry is valid
PCplus4Out  output  PC_W  PC+4 of the head entry; 0 when empty
instructionOut  output  DATA_W  head instruction; 0 (NOP) when empty
count  output  CNT_W  number of occupied entries, 0..DEPTH

Behaviour:
- Reset: synchronous and active-high. On rst=1 at a clock edge, the following are cleared: read and write pointers; count=0; out_valid=0; PCplus4Out=0; instructionOut=0; in_ready=1 after that edge. Storage contents need not be cleared.
- Push: occurs when in_valid && in_ready. The entry is written at wr_ptr, which then increments modulo DEPTH.
- Pop: occurs when EN && out_valid. rd_ptr increments modulo DEPTH.
- EN=0: no pop. Head outputs hold their values. Pushes still occur while in_ready=1.
- in_ready = (count != DEPTH):
  - decoded from registered count only; no combinational path from EN or flush;
  - a full queue refuses a push even in a cycle when a pop occurs.
- Outputs:
  - out_valid = (count != 0);
  - PCplus4Out and instructionOut come from the storage entry at rd_ptr, forced to 0 when count == 0;
  - there is no combinational path from any input to any output.
- Latency: an entry pushed at edge t is visible at the head after edge t (1 cycle) when the queue was empty. It is never visible in the same cycle it is presented (no bypass).
- Count update per edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- Ordering: strict FIFO. Wrap-around of both pointers is seamless.
- Priority per edge: rst > flush > normal push/pop.
  - flush=1 empties the queue: pointers and count go to 0, and head outputs read 0 after the edge.
  - flush overrides EN=0. A stalled decode does not block a flush.
  - An entry presented with in_valid in a flush cycle is dropped.
  - Any pop in a flush cycle is also discarded.
- Empty with EN=1: no pop and no underflow. Outputs stay 0 and out_valid stays 0.
- Full with in_valid=1: entry not accepted. IF must hold it, and queue state is unchanged.
- Reset asserted mid-operation: all entries are lost, with the same end state as power-on reset.
- Overflow of count or the pointers is impossible by construction. An assertion must flag count > DEPTH.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, out_valid=0, instructionOut=0, PCplus4Out=0, in_ready=1.
- Single pass: push {PC+4=0x4, instr=0x20080005} with EN=1 -> next cycle out_valid=1, instructionOut=0x20080005. Following cycle (popped) -> out_valid=0, instructionOut=0.
- Fill under stall (DEPTH=4): EN=0, push 0x11,0x22,0x33,0x44 -> count=4, in_ready=0. Fifth push 0x55 is refused and count stays 4. Then EN=1 for 4 cycles -> head sequence 0x11,0x22,0x33,0x44, then empty.
- Simultaneous push/pop with wrap: stream 10 entries 0x1..0xA with EN=1, in_valid=1 continuously -> outputs 0x1..0xA in order, one cycle behind input, count stays 1, and pointers wrap twice without loss.
- Flush beats stall: with 3 entries queued, drive EN=0, flush=1, in_valid=1 (instr 0x99) -> after the edge count=0, out_valid=0, instructionOut=0, and 0x99 is never output.
- Reset mid-stream: with 2 entries queued and a push in flight, assert rst=1 -> after the edge the state matches the power-on reset state. The next push 0x77 appears as the head one cycle later.
